// File: rtl/i_wb_arbiter.sv
// Integer write-back arbiter: round-robin selection of up to WRITE_PORTS results per cycle
// into registered register-file write ports. Optional per-channel skid buffer under WB_SKID_EN.
module i_wb_arbiter #(
    parameter int CHANNELS    = 4,
    parameter int WRITE_PORTS = 2,
    parameter int XLEN        = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 flush_i,
    input  logic [CHANNELS-1:0]                  res_valid_i,
    output logic [CHANNELS-1:0]                  res_ready_o,
    input  logic [CHANNELS-1:0][4:0]             res_addr_i,
    input  logic [CHANNELS-1:0][XLEN-1:0]        res_data_i,
    output logic [WRITE_PORTS-1:0]               we_o,
    output logic [WRITE_PORTS-1:0][4:0]          wr_iaddr_o,
    output logic [WRITE_PORTS-1:0][XLEN-1:0]     wr_idata_o
);
    localparam int PW = $clog2(CHANNELS);

    logic [PW-1:0]                     r_ptr;
    logic [CHANNELS-1:0]               w_cand_v;
    logic [CHANNELS-1:0][4:0]          w_cand_a;
    logic [CHANNELS-1:0][XLEN-1:0]     w_cand_d;
    logic [CHANNELS-1:0]               w_take;
    logic [WRITE_PORTS-1:0]            w_we;
    logic [WRITE_PORTS-1:0][4:0]       w_addr;
    logic [WRITE_PORTS-1:0][XLEN-1:0]  w_data;
    logic                              w_any;
    logic [PW-1:0]                     w_last;

`ifdef WB_SKID_EN
    logic [CHANNELS-1:0]               r_skid_full;
    logic [CHANNELS-1:0][4:0]          r_skid_addr;
    logic [CHANNELS-1:0][XLEN-1:0]     r_skid_data;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_cand_v[c] = r_skid_full[c] | res_valid_i[c];
            w_cand_a[c] = r_skid_full[c] ? r_skid_addr[c] : res_addr_i[c];
            w_cand_d[c] = r_skid_full[c] ? r_skid_data[c] : res_data_i[c];
        end
    end

    // Ready comes only from skid occupancy; flush and reset just mask it.
    assign res_ready_o = ~r_skid_full & {CHANNELS{~flush_i & rst_n_i}};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_skid_full <= '0;
            r_skid_addr <= '0;
            r_skid_data <= '0;
        end else if (flush_i) begin
            r_skid_full <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_take[c]) begin
                    r_skid_full[c] <= 1'b0;
                end else if (!r_skid_full[c] && res_valid_i[c]) begin
                    r_skid_full[c] <= 1'b1;
                    r_skid_addr[c] <= res_addr_i[c];
                    r_skid_data[c] <= res_data_i[c];
                end
            end
        end
    end
`else
    assign w_cand_v    = res_valid_i;
    assign w_cand_a    = res_addr_i;
    assign w_cand_d    = res_data_i;
    assign res_ready_o = w_take;
`endif

    // Scan from r_ptr; X0 results retire without a port, duplicates of a granted
    // destination wait, everything else fills ports in scan order.
    always_comb begin
        logic [PW-1:0] idx;
        int            n;
        logic          hit;
        w_take = '0;
        w_we   = '0;
        w_addr = '0;
        w_data = '0;
        w_any  = 1'b0;
        w_last = '0;
        idx    = '0;
        n      = 0;
        hit    = 1'b0;
        if (!flush_i && rst_n_i) begin
            for (int i = 0; i < CHANNELS; i++) begin
                idx = r_ptr + PW'(i);
                if (w_cand_v[idx]) begin
                    if (w_cand_a[idx] == 5'd0) begin
                        w_take[idx] = 1'b1;
                        w_any       = 1'b1;
                        w_last      = idx;
                    end else begin
                        hit = 1'b0;
                        for (int k = 0; k < WRITE_PORTS; k++) begin
                            if (w_we[k] && (w_addr[k] == w_cand_a[idx])) hit = 1'b1;
                        end
                        if (!hit && (n < WRITE_PORTS)) begin
                            for (int k = 0; k < WRITE_PORTS; k++) begin
                                if (k == n) begin
                                    w_we[k]   = 1'b1;
                                    w_addr[k] = w_cand_a[idx];
                                    w_data[k] = w_cand_d[idx];
                                end
                            end
                            n           = n + 1;
                            w_take[idx] = 1'b1;
                            w_any       = 1'b1;
                            w_last      = idx;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr      <= '0;
            we_o       <= '0;
            wr_iaddr_o <= '0;
            wr_idata_o <= '0;
        end else if (flush_i) begin
            r_ptr <= '0;
            we_o  <= '0;
        end else begin
            we_o <= w_we;
            if (w_any) r_ptr <= w_last + 1'b1;
            for (int k = 0; k < WRITE_PORTS; k++) begin
                if (w_we[k]) begin
                    wr_iaddr_o[k] <= w_addr[k];
                    wr_idata_o[k] <= w_data[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_i_wb_arbiter.sv
// Self-checking bench for i_wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based arbitration model (WB_SKID_EN selects the skid scenario).
module tb_i_wb_arbiter;
    localparam int C  = 4;
    localparam int WP = 2;
    localparam int XL = 32;

    logic                     clk_i = 1'b0;
    logic                     rst_n_i;
    logic                     flush_i;
    logic [C-1:0]             res_valid_i;
    logic [C-1:0]             res_ready_o;
    logic [C-1:0][4:0]        res_addr_i;
    logic [C-1:0][XL-1:0]     res_data_i;
    logic [WP-1:0]            we_o;
    logic [WP-1:0][4:0]       wr_iaddr_o;
    logic [WP-1:0][XL-1:0]    wr_idata_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    int                    m_ptr;
    logic [WP-1:0]         m_we;
    logic [WP-1:0][4:0]    m_addr;
    logic [WP-1:0][XL-1:0] m_data;
    logic [C-1:0]          m_take;
    int                    n_ptr;
    logic [WP-1:0]         n_we;
    logic [WP-1:0][4:0]    n_addr;
    logic [WP-1:0][XL-1:0] n_data;

    i_wb_arbiter #(.CHANNELS(C), .WRITE_PORTS(WP), .XLEN(XL)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .res_valid_i (res_valid_i),
        .res_ready_o (res_ready_o),
        .res_addr_i  (res_addr_i),
        .res_data_i  (res_data_i),
        .we_o        (we_o),
        .wr_iaddr_o  (wr_iaddr_o),
        .wr_idata_o  (wr_idata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_we   = '0;
        m_addr = '0;
        m_data = '0;
        m_take = '0;
    endtask

    // One cycle of arbitration from the visible inputs, using a list of granted destinations.
    task automatic model_arb();
        int  granted[$];
        int  last;
        bit  any;
        bit  dup;
        int  c;
        granted.delete();
        m_take = '0;
        n_we   = '0;
        n_addr = m_addr;
        n_data = m_data;
        n_ptr  = m_ptr;
        last   = 0;
        any    = 0;
        if (flush_i) begin
            n_ptr = 0;
        end else begin
            for (int i = 0; i < C; i++) begin
                c = (m_ptr + i) % C;
                if (res_valid_i[c]) begin
                    if (res_addr_i[c] == 5'd0) begin
                        m_take[c] = 1'b1;
                        last = c;
                        any  = 1;
                    end else begin
                        dup = 0;
                        foreach (granted[j]) if (granted[j] == int'(res_addr_i[c])) dup = 1;
                        if (!dup && granted.size() < WP) begin
                            n_we[granted.size()]   = 1'b1;
                            n_addr[granted.size()] = res_addr_i[c];
                            n_data[granted.size()] = res_data_i[c];
                            granted.push_back(int'(res_addr_i[c]));
                            m_take[c] = 1'b1;
                            last = c;
                            any  = 1;
                        end
                    end
                end
            end
            if (any) n_ptr = (last + 1) % C;
        end
    endtask

    // Called at posedge+1 with inputs set; checks ready mid-cycle and outputs after the edge.
    task automatic cycle();
        @(negedge clk_i);
        model_arb();
        chk("ready", 64'(res_ready_o), 64'(m_take));
        @(posedge clk_i);
        #1;
        m_we   = n_we;
        m_addr = n_addr;
        m_data = n_data;
        m_ptr  = n_ptr;
        chk("we", 64'(we_o), 64'(m_we));
        chk("waddr", 64'(wr_iaddr_o), 64'(m_addr));
        chk("wdata", 64'(wr_idata_o), 64'(m_data));
    endtask

    task automatic clear_inputs();
        res_valid_i = '0;
        res_addr_i  = '0;
        res_data_i  = '0;
        flush_i     = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n_i = 1'b0;
        clear_inputs();
        #1;
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_addr", 64'(wr_iaddr_o), 64'd0);
        chk("rst_data", 64'(wr_idata_o), 64'd0);
        model_reset();
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int c, input logic [4:0] a, input logic [XL-1:0] d);
        res_valid_i[c] = 1'b1;
        res_addr_i[c]  = a;
        res_data_i[c]  = d;
    endtask

    initial begin
        rst_n_i = 1'b0;
        clear_inputs();
        model_reset();
        reset_dut();

`ifdef WB_SKID_EN
        chk("skid_rdy_rst", 64'(res_ready_o), 64'hF);
        drive(0, 5'd1, 32'h1);
        drive(1, 5'd2, 32'h2);
        drive(2, 5'd3, 32'h3);
        @(posedge clk_i); #1;
        res_valid_i = '0;
        chk("skid_we1", 64'(we_o), 64'b11);
        chk("skid_addr1", 64'(wr_iaddr_o), {54'd0, 5'd2, 5'd1});
        chk("skid_rdy1", 64'(res_ready_o), 64'b1011);
        @(posedge clk_i); #1;
        chk("skid_we2", 64'(we_o), 64'b01);
        chk("skid_addr2", 64'(wr_iaddr_o[0]), 64'd3);
        chk("skid_data2", 64'(wr_idata_o[0]), 64'h3);
        chk("skid_rdy2", 64'(res_ready_o), 64'hF);
        reset_dut();
        drive(0, 5'd1, 32'h1);
        drive(1, 5'd2, 32'h2);
        drive(2, 5'd3, 32'h3);
        @(posedge clk_i); #1;
        res_valid_i = '0;
        chk("skidf_rdy1", 64'(res_ready_o), 64'b1011);
        flush_i = 1'b1;
        #1;
        chk("skidf_rdy_fl", 64'(res_ready_o), 64'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        #1;
        chk("skidf_we", 64'(we_o), 64'd0);
        chk("skidf_rdy2", 64'(res_ready_o), 64'hF);
        @(posedge clk_i); #1;
        chk("skidf_we2", 64'(we_o), 64'd0);
`else
        // two distinct destinations, ptr=0
        drive(0, 5'd3, 32'h11);
        drive(1, 5'd4, 32'h22);
        cycle();
        res_valid_i = '0;
        chk("t1_we", 64'(we_o), 64'b11);
        chk("t1_p0", {27'd0, wr_iaddr_o[0], wr_idata_o[0]}, {27'd0, 5'd3, 32'h11});
        chk("t1_p1", {27'd0, wr_iaddr_o[1], wr_idata_o[1]}, {27'd0, 5'd4, 32'h22});
        drive(1, 5'd9, 32'h91);
        drive(2, 5'd10, 32'h92);
        drive(3, 5'd11, 32'h93);
        cycle();
        chk("t1_ptr", 64'(wr_iaddr_o[0]), 64'd10);
        res_valid_i = res_valid_i & ~m_take;
        cycle();
        res_valid_i = '0;

        // four channels, two cycles, ptr wraps to 0
        reset_dut();
        for (int c = 0; c < C; c++) drive(c, 5'(c + 1), 32'(c + 32'h100));
        cycle();
        chk("t2_rdy1", 64'(m_take), 64'b0011);
        chk("t2_a1", 64'(wr_iaddr_o), {54'd0, 5'd2, 5'd1});
        res_valid_i = res_valid_i & ~m_take;
        cycle();
        chk("t2_a2", 64'(wr_iaddr_o), {54'd0, 5'd4, 5'd3});
        res_valid_i = '0;
        drive(3, 5'd12, 32'h33);
        drive(0, 5'd13, 32'h44);
        cycle();
        chk("t2_wrap", 64'(wr_iaddr_o[0]), 64'd13);
        res_valid_i = '0;

        // same destination on two channels
        reset_dut();
        drive(0, 5'd5, 32'hA);
        drive(1, 5'd5, 32'hB);
        cycle();
        chk("t3_we1", 64'(we_o), 64'b01);
        chk("t3_d1", 64'(wr_idata_o[0]), 64'hA);
        res_valid_i = res_valid_i & ~m_take;
        cycle();
        chk("t3_we2", 64'(we_o), 64'b01);
        chk("t3_d2", 64'(wr_idata_o[0]), 64'hB);
        res_valid_i = '0;

        // X0 discard uses no port
        reset_dut();
        drive(0, 5'd0, 32'hDEAD);
        drive(1, 5'd7, 32'h1);
        drive(2, 5'd8, 32'h2);
        cycle();
        chk("t4_rdy", 64'(m_take), 64'b0111);
        chk("t4_a", 64'(wr_iaddr_o), {54'd0, 5'd8, 5'd7});
        res_valid_i = '0;
        cycle();

        // asynchronous reset while both ports write
        drive(0, 5'd9, 32'h9);
        drive(1, 5'd10, 32'hA);
        cycle();
        chk("t5_we_pre", 64'(we_o), 64'b11);
        res_valid_i = 4'b0100;
        res_addr_i[2] = 5'd11;
        rst_n_i = 1'b0;
        #1;
        chk("t5_we_async", 64'(we_o), 64'd0);
        chk("t5_rdy_rst", 64'(res_ready_o), 64'd0);
        clear_inputs();
        model_reset();
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < 3; i++) cycle();

        // randomized traffic with occasional flushes; producers hold until accepted
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush_i = ($urandom_range(0, 19) == 0);
            cycle();
            for (int c = 0; c < C; c++) begin
                if (m_take[c] || flush_i) res_valid_i[c] = 1'b0;
                if (!res_valid_i[c] && $urandom_range(0, 2) != 0) begin
                    res_valid_i[c] = 1'b1;
                    res_addr_i[c]  = 5'($urandom_range(0, 7));
                    res_data_i[c]  = $urandom;
                end
            end
        end
        clear_inputs();
        cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
